// File: rtl/store_buffer_if.sv
// Store-buffer bus: pipeline store/load requests, data_memory port and status.
// STBUF_STATS_EN adds the stall_cycles/full_cycles statistic signals.
interface store_buffer_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [2:0]       st_width;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic [2:0]       ld_width;
    logic             ld_hazard;
    logic             mem_write_enable;
    logic [31:0]      mem_addr;
    logic [2:0]       mem_width;
    logic [31:0]      mem_write_data;
    logic             empty;
    logic [CNT_W-1:0] count;
`ifdef STBUF_STATS_EN
    logic [15:0]      stall_cycles;
    logic [15:0]      full_cycles;
`endif

    modport master (
        output st_valid, st_addr, st_data, st_width, ld_valid, ld_addr, ld_width,
        input  st_ready, ld_hazard, mem_write_enable, mem_addr, mem_width, mem_write_data,
        input  empty, count
`ifdef STBUF_STATS_EN
        , input stall_cycles, full_cycles
`endif
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_width, ld_valid, ld_addr, ld_width,
        output st_ready, ld_hazard, mem_write_enable, mem_addr, mem_width, mem_write_data,
        output empty, count
`ifdef STBUF_STATS_EN
        , output stall_cycles, full_cycles
`endif
    );
endinterface

// File: rtl/store_buffer.sv
// In-order store queue in front of data_memory; loads own the port unless they hit a queued word.
// Optional STBUF_STATS_EN adds saturating hazard-stall and queue-full cycle counters.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  width;
        logic        valid;
    } entry_t;

    entry_t           entry_q [DEPTH];
    entry_t           entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic is_empty;
    logic push;
    logic word_hit;
    logic hazard;
    logic drain;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        is_empty = (count_q == '0);
        push     = bus.st_valid && !full;
    end

    // Word-granular match only; a store accepted this cycle is not yet visible here.
    always_comb begin
        word_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_q[i].valid && (entry_q[i].addr[31:2] == bus.ld_addr[31:2])) begin
                word_hit = 1'b1;
            end
        end
    end

    // Reset suppresses any write so a discarded queue never reaches memory.
    always_comb begin
        hazard = bus.ld_valid && word_hit && !reset;
        drain  = !is_empty && (!bus.ld_valid || hazard) && !reset;
    end

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            entry_d[tail_q] = '{addr:  bus.st_addr,
                                data:  bus.st_data,
                                width: bus.st_width,
                                valid: 1'b1};
            tail_d = tail_q + 1'b1;
        end
        // Push and drain never target the same slot: that needs full or empty.
        if (drain) begin
            entry_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(drain);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        bus.st_ready  = !full;
        bus.empty     = is_empty;
        bus.count     = count_q;
        bus.ld_hazard = hazard;
        if (drain) begin
            bus.mem_write_enable = 1'b1;
            bus.mem_addr         = entry_q[head_q].addr;
            bus.mem_width        = entry_q[head_q].width;
            bus.mem_write_data   = entry_q[head_q].data;
        end else begin
            bus.mem_write_enable = 1'b0;
            bus.mem_addr         = bus.ld_addr;
            bus.mem_width        = bus.ld_width;
            bus.mem_write_data   = '0;
        end
    end

`ifdef STBUF_STATS_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] full_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            full_cycles_q  <= '0;
        end else begin
            if (hazard && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (bus.st_valid && full && (full_cycles_q != 16'hFFFF)) begin
                full_cycles_q <= full_cycles_q + 16'd1;
            end
        end
    end

    always_comb begin
        bus.stall_cycles = stall_cycles_q;
        bus.full_cycles  = full_cycles_q;
    end
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Randomised + directed bench for store_buffer; the pending-store queue doubles as
// reference model and write scoreboard, checked by a negedge monitor.
module tb_store_buffer;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH)) bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  width;
    } st_t;

    st_t         sb_q[$];
    bit   [31:0] mem [bit [29:0]];
    int          n_checks = 0;
    int          n_fail = 0;
    int          stall_m = 0;
    int          full_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [2:0] width);
        bit [31:0] w;
        w = mem.exists(addr[31:2]) ? mem[addr[31:2]] : 32'h0;
        case (width)
            3'b000:  w[8*addr[1:0] +: 8] = data[7:0];
            3'b001:  w[16*addr[1] +: 16] = data[15:0];
            default: w = data;
        endcase
        mem[addr[31:2]] = w;
    endtask

    function automatic logic [31:0] lbu(input logic [31:0] addr);
        bit [31:0] w;
        w = mem.exists(addr[31:2]) ? mem[addr[31:2]] : 32'h0;
        return {24'h0, w[8*addr[1:0] +: 8]};
    endfunction

    // Monitor: sample settled outputs mid-cycle, then apply what the coming posedge does.
    logic exp_hit, exp_hz, exp_full, exp_drain;
    st_t  head_e;
    always @(negedge clk) begin
        if (reset) begin
            check("reset_no_write", 32'(bus.mem_write_enable), 32'h0);
            sb_q.delete();
            stall_m = 0;
            full_m  = 0;
        end else begin
            exp_hit = 1'b0;
            foreach (sb_q[i]) if (sb_q[i].addr[31:2] == bus.ld_addr[31:2]) exp_hit = 1'b1;
            exp_hz    = bus.ld_valid && exp_hit;
            exp_full  = (sb_q.size() == DEPTH);
            exp_drain = (sb_q.size() != 0) && (!bus.ld_valid || exp_hz);
            check("count", 32'(bus.count), 32'(sb_q.size()));
            check("st_ready", 32'(bus.st_ready), 32'(!exp_full));
            check("empty", 32'(bus.empty), 32'(sb_q.size() == 0));
            check("ld_hazard", 32'(bus.ld_hazard), 32'(exp_hz));
            check("write_enable", 32'(bus.mem_write_enable), 32'(exp_drain));
            if (exp_drain) begin
                head_e = sb_q.pop_front();
                check("wr_addr", bus.mem_addr, head_e.addr);
                check("wr_width", 32'(bus.mem_width), 32'(head_e.width));
                check("wr_data", bus.mem_write_data, head_e.data);
            end else begin
                check("ld_addr_pass", bus.mem_addr, bus.ld_addr);
                check("ld_width_pass", 32'(bus.mem_width), 32'(bus.ld_width));
                check("ld_wdata_zero", bus.mem_write_data, 32'h0);
            end
            if (bus.mem_write_enable) mem_write(bus.mem_addr, bus.mem_write_data, bus.mem_width);
`ifdef STBUF_STATS_EN
            check("stall_cycles", 32'(bus.stall_cycles), 32'(stall_m));
            check("full_cycles", 32'(bus.full_cycles), 32'(full_m));
            if (exp_hz && stall_m < 16'hFFFF) stall_m++;
            if (bus.st_valid && exp_full && full_m < 16'hFFFF) full_m++;
`endif
            if (bus.st_valid && !exp_full) begin
                sb_q.push_back('{addr: bus.st_addr, data: bus.st_data, width: bus.st_width});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_width = 3'b010;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_width = 3'b010;
    endtask

    task automatic set_st(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] width);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_width = width;
    endtask

    task automatic drain_all(input string name);
        int budget;
        idle();
        budget = 0;
        while (!bus.empty && budget < 20) begin
            tick();
            budget++;
        end
        check(name, 32'(bus.empty), 32'h1);
    endtask

    logic [2:0] ld_codes [5];

    initial begin
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset then idle.
        check("t1_empty", 32'(bus.empty), 32'h1);
        check("t1_count", 32'(bus.count), 32'h0);
        check("t1_st_ready", 32'(bus.st_ready), 32'h1);
        check("t1_we", 32'(bus.mem_write_enable), 32'h0);
`ifdef STBUF_STATS_EN
        check("t1_stall0", 32'(bus.stall_cycles), 32'h0);
        check("t1_full0", 32'(bus.full_cycles), 32'h0);
`endif

        // Single word store drains the cycle after it enters.
        set_st(32'h10, 32'hDEAD_BEEF, 3'b010);
        tick();
        check("t2_we", 32'(bus.mem_write_enable), 32'h1);
        check("t2_addr", bus.mem_addr, 32'h10);
        check("t2_width", 32'(bus.mem_width), 32'h2);
        idle();
        tick();
        check("t2_empty", 32'(bus.empty), 32'h1);

        // Fill behind a non-hitting load, hold a fifth store, then release.
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h100;
        for (int i = 0; i < 5; i++) begin
            set_st(32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 3'b010);
            if (i < 4) tick();
        end
        check("t3_count", 32'(bus.count), 32'h4);
        check("t3_st_ready", 32'(bus.st_ready), 32'h0);
        tick();
        tick();
        check("t3_held", 32'(bus.count), 32'h4);
        bus.ld_valid = 1'b0;
        tick();
        tick();
        bus.st_valid = 1'b0;
        drain_all("t3_drained");

        // Byte store hit by a load to the same word: one stall cycle.
        set_st(32'h20, 32'hAA, 3'b000);
        tick();
        idle();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h23;
        bus.ld_width = 3'b100;
        #1;
        check("t4_hazard", 32'(bus.ld_hazard), 32'h1);
        tick();
        check("t4_hazard_clr", 32'(bus.ld_hazard), 32'h0);
        check("t4_ld_addr", bus.mem_addr, 32'h23);
        check("t4_we0", 32'(bus.mem_write_enable), 32'h0);
        check("t4_lbu", lbu(32'h20), 32'h0000_00AA);
        idle();

        // Three queued, then push+drain each cycle across the wrap.
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h300;
        for (int i = 0; i < 3; i++) begin
            set_st(32'h400 + 32'(4 * i), 32'h5000 + 32'(i), 3'b001);
            tick();
        end
        bus.ld_valid = 1'b0;
        for (int i = 3; i < 9; i++) begin
            set_st(32'h400 + 32'(4 * i), 32'h5000 + 32'(i), 3'b010);
            tick();
            check("t5_count", 32'(bus.count), 32'h3);
        end
        drain_all("t5_drained");

        // Reset with three pending discards them without writing.
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h300;
        for (int i = 0; i < 3; i++) begin
            set_st(32'h600 + 32'(4 * i), 32'h7000 + 32'(i), 3'b010);
            tick();
        end
        bus.st_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_count", 32'(bus.count), 32'h0);
        check("t6_empty", 32'(bus.empty), 32'h1);
        idle();
        tick();

        // Random traffic over a small word window to provoke hazards and wraps.
        for (int c = 0; c < 600; c++) begin
            bus.st_valid = ($urandom_range(0, 9) < 6);
            bus.st_addr  = 32'h800 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            bus.st_data  = $urandom;
            bus.st_width = 3'($urandom_range(0, 2));
            bus.ld_valid = ($urandom_range(0, 9) < 5);
            bus.ld_addr  = 32'h800 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            bus.ld_width = ld_codes[$urandom_range(0, 4)];
            reset        = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;
        drain_all("final_drained");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
